// File: rtl/sift_pkg.sv
// Shared types for the SIFT descriptor datapath: orientation bins and
// the subpatch histogram controller states.
package sift_pkg;

    localparam int unsigned NUM_BINS = 8;

    typedef logic [2:0] orient_bin_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } hist_state_t;

endpackage

// File: rtl/orientation_bin.sv
// Combinational octant classifier for one gradient pair; nonzero is low
// when both components are zero so the sample contributes to no bin.
module orientation_bin
    import sift_pkg::*;
#(
    parameter int unsigned BIT_DEPTH = 8
) (
    input  logic signed [BIT_DEPTH-1:0] gx,
    input  logic signed [BIT_DEPTH-1:0] gy,
    output orient_bin_t                 bin,
    output logic                        nonzero
);

    localparam int unsigned MAG_W = BIT_DEPTH + 1;

    logic             sx, sy;
    logic [MAG_W-1:0] gx_ext, gy_ext, ax, ay;
    logic             x_ge_y;

    always_comb begin
        sx     = gx[BIT_DEPTH-1];
        sy     = gy[BIT_DEPTH-1];
        // One extra bit so the most negative sample has a representable magnitude
        gx_ext = {sx, gx};
        gy_ext = {sy, gy};
        ax     = sx ? (~gx_ext + MAG_W'(1)) : gx_ext;
        ay     = sy ? (~gy_ext + MAG_W'(1)) : gy_ext;
        x_ge_y = (ax >= ay);
        nonzero = (gx != '0) || (gy != '0);
        bin = 3'd0;
        case ({sx, sy})
            2'b00:   bin = x_ge_y ? 3'd0 : 3'd1;
            2'b10:   bin = x_ge_y ? 3'd3 : 3'd2;
            2'b11:   bin = x_ge_y ? 3'd4 : 3'd5;
            2'b01:   bin = x_ge_y ? 3'd7 : 3'd6;
            default: bin = 3'd0;
        endcase
    end

endmodule

// File: rtl/subpatch_histogram.sv
// Walks one subpatch of the gradient BRAMs in raster order and accumulates
// a saturating 8-bin orientation histogram, presented with a one-cycle valid.
module subpatch_histogram
    import sift_pkg::*;
#(
    parameter int unsigned DIMENSION    = 64,
    parameter int unsigned BIT_DEPTH    = 8,
    parameter int unsigned PATCH_SIZE   = 4,
    parameter int unsigned READ_LATENCY = 2,
    localparam int unsigned COORD_W = $clog2(DIMENSION),
    localparam int unsigned ADDR_W  = $clog2(DIMENSION * DIMENSION),
    localparam int unsigned WL_W    = $clog2(COORD_W + 1),
    localparam int unsigned SUB     = PATCH_SIZE / 2,
    localparam int unsigned N       = SUB * SUB,
    localparam int unsigned COUNT_W = $clog2(N)
) (
    input  logic                        clk,
    input  logic                        rst_in,
    input  logic                        start,
    input  logic [COORD_W-1:0]          origin_x,
    input  logic [COORD_W-1:0]          origin_y,
    input  logic [WL_W-1:0]             width_log2,
    output logic [ADDR_W-1:0]           grad_addr,
    input  logic signed [BIT_DEPTH-1:0] grad_x,
    input  logic signed [BIT_DEPTH-1:0] grad_y,
    output logic                        busy,
    output logic                        hist_valid,
    output logic [NUM_BINS*COUNT_W-1:0] hist_out
);

    localparam int unsigned SUB_W = (SUB > 1) ? $clog2(SUB) : 1;

    hist_state_t                      state_q, state_d;
    logic [COORD_W-1:0]               ox_q, oy_q;
    logic [WL_W-1:0]                  wl_q;
    logic [SUB_W-1:0]                 col_q, row_q;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [READ_LATENCY-1:0]          tag_q, tag_d;
    logic                             data_vld_q, bin_vld_q;
    logic signed [BIT_DEPTH-1:0]      gx_q, gy_q;
    orient_bin_t                      bin_d, bin_q;
    logic                             nonzero;
    logic [NUM_BINS-1:0][COUNT_W-1:0] cnt_q;
    logic                             issue, last;
    logic [COORD_W:0]                 lim, x_sum, y_sum, x_cl, y_cl;

    orientation_bin #(
        .BIT_DEPTH(BIT_DEPTH)
    ) u_orientation_bin (
        .gx     (gx_q),
        .gy     (gy_q),
        .bin    (bin_d),
        .nonzero(nonzero)
    );

    // Coordinates past the level edge replicate the last pixel
    always_comb begin
        lim    = ((COORD_W + 1)'(1) << wl_q) - (COORD_W + 1)'(1);
        x_sum  = {1'b0, ox_q} + (COORD_W + 1)'(col_q);
        y_sum  = {1'b0, oy_q} + (COORD_W + 1)'(row_q);
        x_cl   = (x_sum > lim) ? lim : x_sum;
        y_cl   = (y_sum > lim) ? lim : y_sum;
        addr_d = (ADDR_W'(y_cl) << wl_q) | ADDR_W'(x_cl);
        last   = (col_q == SUB_W'(SUB - 1)) && (row_q == SUB_W'(SUB - 1));
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: begin
                issue = 1'b1;
                if (last) state_d = StDrain;
            end
            // Leave once only the final bin remains; it is counted on the edge entering DONE
            StDrain: if ((tag_q == '0) && !data_vld_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        tag_d    = tag_q << 1;
        tag_d[0] = issue;
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= StIdle;
            ox_q       <= '0;
            oy_q       <= '0;
            wl_q       <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            tag_q      <= '0;
            data_vld_q <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
            bin_vld_q  <= 1'b0;
            bin_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            data_vld_q <= tag_q[READ_LATENCY-1];
            if (tag_q[READ_LATENCY-1]) begin
                gx_q <= grad_x;
                gy_q <= grad_y;
            end
            bin_vld_q <= data_vld_q && nonzero;
            bin_q     <= bin_d;

            if ((state_q == StIdle) && start) begin
                ox_q  <= origin_x;
                oy_q  <= origin_y;
                wl_q  <= width_log2;
                col_q <= '0;
                row_q <= '0;
                cnt_q <= '0;
            end else if (bin_vld_q && (cnt_q[bin_q] != '1)) begin
                cnt_q[bin_q] <= cnt_q[bin_q] + COUNT_W'(1);
            end

            if (issue) begin
                addr_q <= addr_d;
                if (col_q == SUB_W'(SUB - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + SUB_W'(1);
                end else begin
                    col_q <= col_q + SUB_W'(1);
                end
            end
        end
    end

    assign grad_addr  = addr_q;
    assign busy       = (state_q != StIdle);
    assign hist_valid = (state_q == StDone);
    assign hist_out   = cnt_q;

endmodule

// File: doc/subpatch_histogram.md
# subpatch_histogram

Computes the 8-bin gradient-orientation histogram of one (PATCH_SIZE/2)×(PATCH_SIZE/2) subpatch of a gradient-pyramid level. It sits directly under `generate_descriptors`, which muxes the gradient BRAMs and pulses `start` once per subpatch. The block reads the x/y gradient pairs, bins each sample by octant and returns the packed bin counts with a one-cycle `hist_valid`; the descriptor stage writes that word straight into the descriptor BRAM.

## Interface
- `DIMENSION`, 64: top-level image side; sets address and coordinate widths.
- `BIT_DEPTH`, 8: signed gradient sample width.
- `PATCH_SIZE`, 4: keypoint patch side; subpatch side is SUB = PATCH_SIZE/2, with N = SUB*SUB samples.
- `READ_LATENCY`, 2: gradient BRAM read latency in cycles.
- Derived `COUNT_W` = $clog2(N) (2 at defaults). `hist_out` is 8*COUNT_W wide (16 bits).

Ports:
- `clk`, in, 1: sole clock.
- `rst_in`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request a histogram; sampled only in IDLE.
- `origin_x`, `origin_y`, in, $clog2(DIMENSION) each: top-left corner of the subpatch.
- `width_log2`, in, $clog2($clog2(DIMENSION)+1): log2 of the current level width (6/5/4 for O1/O2/O3). Latched at start.
- `grad_addr`, out, $clog2(DIMENSION*DIMENSION): shared read address for the x and y gradient BRAMs.
- `grad_x`, `grad_y`, in, BIT_DEPTH, signed: BRAM read data.
- `busy`, out, 1: high from the cycle after an accepted start until `hist_valid` inclusive.
- `hist_valid`, out, 1: one-cycle pulse; `hist_out` is valid in that cycle.
- `hist_out`, out, 8*COUNT_W: bin b is `hist_out[b*COUNT_W +: COUNT_W]`. Held until the next accepted start.

## Operation
- FSM states:
  - IDLE: on `start`, latch origin and `width_log2`, clear the counters, go to ISSUE.
  - ISSUE: emit N addresses, one per cycle, then go to DRAIN.
  - DRAIN: wait until the last sample has been accumulated, then go to DONE.
  - DONE: pulse `hist_valid`, return to IDLE.
- Address order is raster: for r in 0..SUB-1, for c in 0..SUB-1, emit (x = ox+c, y = oy+r).
- grad_addr = (y << width_log2) | x.
- Clamping: a coordinate exceeding (1<<width_log2)-1 is clamped to (1<<width_log2)-1, so edge pixels are replicated.
- Sample tracking: a valid-tag shift register READ_LATENCY deep marks which returned BRAM words are real samples.
- Binning uses ax = |gx| and ay = |gy| at BIT_DEPTH+1 bits, so -128 maps to 128:
  - gx ≥ 0, gy ≥ 0: ax ≥ ay → bin 0, else bin 1.
  - gx < 0, gy ≥ 0: ay > ax → bin 2, else bin 3.
  - gx < 0, gy < 0: ax ≥ ay → bin 4, else bin 5.
  - gx ≥ 0, gy < 0: ay > ax → bin 6, else bin 7.
  - gx = gy = 0: no bin is incremented.
- Counters saturate at 2^COUNT_W - 1 and never wrap.
- `start` in any state other than IDLE is ignored; a held `start` re-triggers on return to IDLE.
- Reset, including mid-operation, forces IDLE, drops the valid tags, and suppresses `hist_valid`.

## Timing
- Reset values: `grad_addr` = 0, `busy` = 0, `hist_valid` = 0, `hist_out` = 0, all counters 0.
- Start sampled at edge t0. The first address is registered at t0+1 and sample k's address at t0+1+k.
- Data for sample k is captured at t0+1+k+READ_LATENCY, the bin is registered one cycle later, and the count updates one cycle after that.
- `hist_valid` is high in cycle t0 + N + READ_LATENCY + 2, which is 8 cycles at defaults. `busy` falls in the following cycle.
- Back-to-back throughput: a new start is accepted in the cycle after `hist_valid`.
- `grad_addr` holds its last value outside ISSUE.

## Structure
- `sift_pkg` holds: the `orient_bin_t` 3-bit typedef, NUM_BINS = 8, and the FSM state enum `hist_state_t`.
- Sub-module `orientation_bin`: purely combinational; (gx, gy) → {bin, nonzero}. The parent registers its output.
- The parent contains: the FSM, address generator, latency tag shift register, and saturating counters.

## Test plan
- **Reset:** hold `rst_in` = 0 with random inputs → all outputs 0; no `hist_valid` for 20 cycles after release without `start`.
- **Single bin, saturation:** origin (4,4), width_log2 = 6, every sample (10,3) → addresses 260, 261, 324, 325; `hist_valid` at t0+8; `hist_out` = 16'h0003 (bin 0 saturated at 3).
- **Mixed bins:** samples (3,5), (-7,2), (-2,-9), (4,-1) → bins 1, 3, 5, 7 → `hist_out` = 16'h4444.
- **Ties, zeros, -128:** samples (5,5), (-128,127), (0,-4), (0,0) → bins 0, 3, 6; `hist_out` = 16'h1041; `hist_valid` still pulses.
- **Edge clamp:**
  - origin (63,63), width_log2 = 6 → `grad_addr` = 4095 four times.
  - origin (31,2), width_log2 = 5 → addresses 95, 95, 127, 127.
- **Control robustness:**
  - `start` pulsed mid-ISSUE → ignored; exactly one `hist_valid`.
  - `rst_in` asserted in DRAIN → IDLE; no `hist_valid`; `hist_out` = 0.
